cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
- Round-robin arbiter and broadcast register for the Common Data Bus (CDB) in the Tomasulo core.
- Collects completion requests from the execution units: ALU (src 0), load/store buffer (src 1), and a spare unit (src 2).
- Grants at most one request per cycle and drives the registered CDB broadcast seen by the RS, ROB and LSB.
- Grant is combinational. Each requester holds valid until granted, then drops valid at the same edge the arbiter captures its payload.

Parameters:
NUM_SRC, 3, number of requesters; source i occupies slice i of each packed bus, source 0 at LSBs.
ROB_W, 4, ROB tag width; must equal `ROB_ID_WIDTH.
DATA_W, 32, value and target-address width.

Ports:
clk  input  1  system clock, all state on rising edge.
rst  input  1  reset, asynchronous, active-low (rst==0 resets).
flush_i  input  1  pipeline flush on branch mispredict, synchronous, active-high.
req_valid_i  input  NUM_SRC  per-source CDB request.
req_rob_id_i  input  NUM_SRC*ROB_W  per-source destination ROB tag.
req_value_i  input  NUM_SRC*DATA_W  per-source result value.
req_target_i  input  NUM_SRC*DATA_W  per-source branch/jump target.
req_taken_i  input  NUM_SRC  per-source branch outcome (1 = taken).
grant_o  output  NUM_SRC  one-hot combinational grant.
cdb_valid_o  output  1  broadcast valid.
cdb_rob_id_o  output  ROB_W  broadcast ROB tag.
cdb_value_o  output  DATA_W  broadcast value.
cdb_target_o  output  DATA_W  broadcast target.
cdb_taken_o  output  1  broadcast branch outcome.
cdb_src_o  output  2  index of the source that produced the current broadcast.

Behaviour:
- Reset (rst low, asynchronous):
  - All cdb_* outputs go to 0; pointer ptr goes to 0.
  - grant_o is forced to 0 while rst is low.
  - Reset mid-broadcast drops the broadcast immediately; nothing is replayed.
- Grant (combinational):
  - Scan sources ptr, ptr+1, … wrapping modulo NUM_SRC; grant the first with req_valid_i set.
  - grant_o is all-zero when no request is present or flush_i==1.
  - grant_o is never more than one-hot.
- Capture (rising edge, rst high):
  - If any grant: cdb_valid_o<=1; rob_id, value, target and taken are loaded from the granted slice; cdb_src_o<=granted index; ptr<=(granted+1) mod NUM_SRC.
  - Otherwise: cdb_valid_o<=0; payload registers hold; ptr holds.
- Latency and throughput:
  - Request granted in cycle N appears on the CDB in cycle N+1.
  - One broadcast per cycle; back-to-back broadcasts with no bubble while requests are pending.
- Handshake:
  - Requester holds valid and payload stable until it samples grant high at a rising edge.
  - The arbiter does not buffer; an ungranted request is re-arbitrated next cycle.
- Fairness:
  - A continuously asserted request is granted within NUM_SRC cycles.
  - A lone requester is granted every cycle.
- Flush:
  - Sets grant_o to 0 in the same cycle; cdb_valid_o<=0 at the next edge; ptr is unchanged.
  - A broadcast already registered in the flush cycle is still visible that cycle; the ROB discards it.
- Pointer wrap: when granted index is NUM_SRC-1, ptr goes to 0.
- Simultaneous requests: always resolved by ptr, never by fixed index.
- Payload of non-granted slices is ignored; X values on them must not propagate.

Test Plan:
1. Reset while cdb_valid_o=1 → all cdb outputs 0 immediately without a clock edge; after release, first request from src 2 alone → grant_o=3'b100, next cycle cdb_src_o=2.
2. Single ALU request, rob_id=5, value=32'h0000_0010, taken=0 → grant_o=3'b001 same cycle; next cycle cdb_valid_o=1, cdb_rob_id_o=5, cdb_value_o=32'h10; cycle after (no request) cdb_valid_o=0.
3. All three request continuously from reset → grants 001, 010, 100, 001 on consecutive cycles; cdb_src_o sequence 0,1,2,0 one cycle later; no bubble.
4. Src 1 requests with rob_id=7, target=32'h0000_1000, taken=1, while src 0 requests with ptr=1 → src 1 granted first; CDB shows rob_id 7, target 32'h1000, taken 1; src 0 granted next cycle.
5. flush_i=1 with src 0 and src 2 requesting → grant_o=0, next cycle cdb_valid_o=0, ptr unchanged; after flush_i falls, the original ptr order resumes.
6. Src 0 alone requests for 4 cycles → granted all 4 cycles; cdb_valid_o held high 4 consecutive cycles with the corresponding rob_ids.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter and registered broadcast stage for the Common Data Bus.
// Grant is combinational; the granted slice is captured into the CDB register on the next edge.

`ifndef ROB_ID_WIDTH
`define ROB_ID_WIDTH 4
`endif

module cdb_arbiter #(
    parameter int NUM_SRC = 3,
    parameter int ROB_W   = `ROB_ID_WIDTH,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush_i,
    input  logic [NUM_SRC-1:0]        req_valid_i,
    input  logic [NUM_SRC*ROB_W-1:0]  req_rob_id_i,
    input  logic [NUM_SRC*DATA_W-1:0] req_value_i,
    input  logic [NUM_SRC*DATA_W-1:0] req_target_i,
    input  logic [NUM_SRC-1:0]        req_taken_i,
    output logic [NUM_SRC-1:0]        grant_o,
    output logic                      cdb_valid_o,
    output logic [ROB_W-1:0]          cdb_rob_id_o,
    output logic [DATA_W-1:0]         cdb_value_o,
    output logic [DATA_W-1:0]         cdb_target_o,
    output logic                      cdb_taken_o,
    output logic [1:0]                cdb_src_o
);

    localparam int SRC_W = 2;

    logic [SRC_W-1:0]   r_ptr;
    logic               r_cdb_valid;
    logic [ROB_W-1:0]   r_cdb_rob_id;
    logic [DATA_W-1:0]  r_cdb_value;
    logic [DATA_W-1:0]  r_cdb_target;
    logic               r_cdb_taken;
    logic [SRC_W-1:0]   r_cdb_src;

    logic               w_any;
    logic [SRC_W-1:0]   w_gnt_idx;
    logic [NUM_SRC-1:0] w_grant;
    logic [SRC_W-1:0]   w_ptr_nxt;
    logic [ROB_W-1:0]   w_sel_rob_id;
    logic [DATA_W-1:0]  w_sel_value;
    logic [DATA_W-1:0]  w_sel_target;
    logic               w_sel_taken;

    // Pick the valid source with the smallest rotated distance from the pointer.
    always_comb begin : arbitrate
        int best_d;
        int d;
        best_d    = NUM_SRC;
        d         = 0;
        w_gnt_idx = '0;
        w_any     = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            d = j - int'(r_ptr);
            if (d < 0) begin
                d = d + NUM_SRC;
            end
            if (req_valid_i[j] && (d < best_d)) begin
                best_d    = d;
                w_gnt_idx = SRC_W'(j);
                w_any     = 1'b1;
            end
        end
        if (flush_i || !rst) begin
            w_any = 1'b0;
        end
    end

    always_comb begin
        w_grant = '0;
        for (int j = 0; j < NUM_SRC; j++) begin
            w_grant[j] = w_any && (w_gnt_idx == SRC_W'(j));
        end
    end

    // Only the granted slice reaches the register, so X on idle slices stays out.
    always_comb begin
        w_sel_rob_id = '0;
        w_sel_value  = '0;
        w_sel_target = '0;
        w_sel_taken  = 1'b0;
        for (int j = 0; j < NUM_SRC; j++) begin
            if (w_grant[j]) begin
                w_sel_rob_id = req_rob_id_i[j*ROB_W +: ROB_W];
                w_sel_value  = req_value_i[j*DATA_W +: DATA_W];
                w_sel_target = req_target_i[j*DATA_W +: DATA_W];
                w_sel_taken  = req_taken_i[j];
            end
        end
    end

    always_comb begin
        if (w_gnt_idx == SRC_W'(NUM_SRC - 1)) begin
            w_ptr_nxt = '0;
        end else begin
            w_ptr_nxt = w_gnt_idx + SRC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr        <= '0;
            r_cdb_valid  <= 1'b0;
            r_cdb_rob_id <= '0;
            r_cdb_value  <= '0;
            r_cdb_target <= '0;
            r_cdb_taken  <= 1'b0;
            r_cdb_src    <= '0;
        end else if (w_any) begin
            r_ptr        <= w_ptr_nxt;
            r_cdb_valid  <= 1'b1;
            r_cdb_rob_id <= w_sel_rob_id;
            r_cdb_value  <= w_sel_value;
            r_cdb_target <= w_sel_target;
            r_cdb_taken  <= w_sel_taken;
            r_cdb_src    <= w_gnt_idx;
        end else begin
            r_cdb_valid  <= 1'b0;
        end
    end

    assign grant_o      = w_grant;
    assign cdb_valid_o  = r_cdb_valid;
    assign cdb_rob_id_o = r_cdb_rob_id;
    assign cdb_value_o  = r_cdb_value;
    assign cdb_target_o = r_cdb_target;
    assign cdb_taken_o  = r_cdb_taken;
    assign cdb_src_o    = r_cdb_src;

endmodule
